rns_error_sequencer: RTL and testbench
======================================

# rns_error_sequencer

Sequences the RNS error-polynomial conversion datapath across all active RNS moduli. For each modulus it drives the shared error-BRAM read address over 0..N-1 and presents the modulus q. It also drives the `done_internal` qualifier so the converter's delayed write-enable covers exactly N writes per modulus. The block sits between the top-level key-switch/encrypt controller (start/done handshake) and the error-polynomial converter.

## Interface
Parameters:
- N, 8192, polynomial degree
- LOGN, 13, coefficient address width
- LOGQ, 54, modulus width
- MAXL, 8, modulus table depth
- LOGL, 3, modulus index width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- cfg_we  in  1  modulus table write strobe
- cfg_idx  in  LOGL  table write index
- cfg_q  in  LOGQ  modulus value; must be odd
- start  in  1  start request, sampled in IDLE only
- num_moduli  in  LOGL+1  active modulus count (0..MAXL), sampled with start
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle completion pulse
- read_addr  out  LOGN  error-BRAM read address to the converter
- done_internal  out  1  converter write qualifier; low = write window open
- q  out  LOGQ  current modulus to the converter
- mod_idx  out  LOGL  current modulus index, used by the top level for the destination bank

## Operation
- Modulus table: MAXL registers, reset to 0.
  - Written on cfg_we when not busy.
  - cfg_we while busy is ignored.
  - cfg_idx ≥ MAXL is ignored.
- FSM states IDLE, PRIME, SWEEP, DRAIN, FIN.
  - IDLE: start=1 and num_moduli≠0 → PRIME; latch count, mod_idx=0. start=1 and num_moduli=0 → FIN. num_moduli>MAXL is clamped to MAXL.
  - PRIME (1 cycle): read_addr=0, done_internal=0, q=table[mod_idx] → SWEEP.
  - SWEEP (N cycles): read_addr counts 0..N-1. done_internal=0 for addresses 0..N-2 and 1 on address N-1 → DRAIN.
  - DRAIN (2 cycles): done_internal=1; q, mod_idx and read_addr=N-1 held. Then, if mod_idx+1 < count: mod_idx++ → PRIME; else → FIN.
  - FIN (1 cycle): done=1 → IDLE.
- done_internal=1 in IDLE and FIN.
- q changes only on entry to PRIME. It is constant through the converter's 2-cycle BRAM latency plus 1-cycle done_internal delay, so every write of modulus i uses table[i].
- start during busy is ignored.
- cfg writes that hit the table while IDLE take effect at the next PRIME.

## Timing
- Reset values: busy 0, done 0, read_addr 0, done_internal 1, q 0, mod_idx 0, state IDLE.
- Reset mid-operation returns to IDLE next edge with reset values. The table is also cleared. No done pulse is issued.
- Start accepted at cycle c: PRIME at c+1, first SWEEP cycle at c+2.
- Each modulus takes N+3 cycles. done pulses at c+1+L·(N+3), with busy falling in the same cycle.
- Converter write window: write-enable high for exactly N consecutive cycles per modulus, starting 3 cycles after PRIME, with write addresses 0..N-1 in order.
- With num_moduli=0, done pulses at c+1.
- read_addr wrap from N-1 is not allowed; the counter stops at N-1 on leaving SWEEP.

## Structure
- Shared package `rns_seq_pkg`:
  - state enum {IDLE, PRIME, SWEEP, DRAIN, FIN}
  - localparam DRAIN_CYCLES=2, derived as BRAM_RD_LAT plus the done_internal delay minus 1
- Sub-module `rns_modulus_table` holds the MAXL×LOGQ register file with the write port and an async read by mod_idx.
- The FSM and address counter live in the top module.

## Test plan
- N=16, table={0x3F,0x61}, num_moduli=2, start at cycle 10. Expect read_addr sweeps 0..15 twice, q=0x3F then 0x61, done at cycle 49, busy high cycles 11..48.
- Same run with the converter model attached. Expect 32 writes; bank0 addresses 0..15 written with q=0x3F, bank1 with 0x61; no write during DRAIN/PRIME gaps.
- num_moduli=0 with start. Expect done one cycle later, done_internal stays 1, no writes.
- start pulsed again mid-SWEEP, plus cfg_we to index 0 with 0x7F while busy. Expect both ignored; q remains 0x3F and completion timing is unchanged.
- rst_n low at SWEEP address 7. Expect IDLE next cycle, done_internal=1, read_addr=0, table cleared, no done pulse; a fresh start then completes normally.
- num_moduli=9 with MAXL=8. Expect clamp to 8 moduli, done at c+1+8·(N+3).

Source files
------------

// File: rtl/rns_seq_pkg.sv
// Shared types and timing constants for the RNS error-polynomial sequencer.
package rns_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRIME = 3'd1,
    SWEEP = 3'd2,
    DRAIN = 3'd3,
    FIN   = 3'd4
  } seq_state_t;

  localparam int BRAM_RD_LAT  = 2;
  localparam int DI_DELAY     = 1;
  // Hold q and mod_idx long enough for the converter's last in-flight write.
  localparam int DRAIN_CYCLES = BRAM_RD_LAT + DI_DELAY - 1;
  localparam int DRAIN_W      = $clog2(DRAIN_CYCLES + 1);

endpackage

// File: rtl/rns_modulus_table.sv
// MAXL x LOGQ modulus register file: one synchronous write port, one async read port.
module rns_modulus_table #(
  parameter int MAXL = 8,
  parameter int LOGL = 3,
  parameter int LOGQ = 54
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [LOGL-1:0] wr_idx,
  input  logic [LOGQ-1:0] wr_data,
  input  logic [LOGL-1:0] rd_idx,
  output logic [LOGQ-1:0] rd_data
);

  logic [LOGQ-1:0] regs [MAXL];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MAXL; i++) regs[i] <= '0;
    end else if (we && (int'(wr_idx) < MAXL)) begin
      regs[wr_idx] <= wr_data;
    end
  end

  assign rd_data = (int'(rd_idx) < MAXL) ? regs[rd_idx] : '0;

endmodule

// File: rtl/rns_error_sequencer.sv
// Walks every active RNS modulus, sweeping the error-BRAM address 0..N-1 and
// qualifying the converter's delayed write-enable via done_internal.
//
// state | meaning
// IDLE  | waiting for start; table writable
// PRIME | load q for mod_idx, address 0 presented
// SWEEP | read_addr counts 0..N-1
// DRAIN | converter pipeline flush, q/mod_idx/read_addr held
// FIN   | one-cycle done pulse
module rns_error_sequencer
  import rns_seq_pkg::*;
#(
  parameter int N    = 8192,
  parameter int LOGN = 13,
  parameter int LOGQ = 54,
  parameter int MAXL = 8,
  parameter int LOGL = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_we,
  input  logic [LOGL-1:0] cfg_idx,
  input  logic [LOGQ-1:0] cfg_q,
  input  logic            start,
  input  logic [LOGL:0]   num_moduli,
  output logic            busy,
  output logic            done,
  output logic [LOGN-1:0] read_addr,
  output logic            done_internal,
  output logic [LOGQ-1:0] q,
  output logic [LOGL-1:0] mod_idx
);

  seq_state_t state, state_nxt;

  logic [LOGL:0]        count;
  logic [LOGL:0]        num_c;
  logic [LOGL-1:0]      mod_idx_nxt;
  logic [LOGQ-1:0]      tbl_rd;
  logic [DRAIN_W-1:0]   drain_cnt;
  logic                 last_addr;
  logic                 more_moduli;
  logic                 enter_prime;

  rns_modulus_table #(
    .MAXL (MAXL),
    .LOGL (LOGL),
    .LOGQ (LOGQ)
  ) u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (cfg_we && !busy),
    .wr_idx  (cfg_idx),
    .wr_data (cfg_q),
    .rd_idx  (mod_idx_nxt),
    .rd_data (tbl_rd)
  );

  assign num_c       = (num_moduli > (LOGL+1)'(MAXL)) ? (LOGL+1)'(MAXL) : num_moduli;
  assign last_addr   = (read_addr == LOGN'(N - 1));
  assign more_moduli = (({1'b0, mod_idx} + (LOGL+1)'(1)) < count);
  assign enter_prime = (state_nxt == PRIME) && (state != PRIME);
  assign mod_idx_nxt = (state == IDLE) ? '0 : mod_idx + LOGL'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (num_moduli == '0) ? FIN : PRIME;
      PRIME: state_nxt = SWEEP;
      SWEEP: if (last_addr) state_nxt = DRAIN;
      DRAIN: if (drain_cnt == '0) state_nxt = more_moduli ? PRIME : FIN;
      FIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy          = (state == PRIME) || (state == SWEEP) || (state == DRAIN);
    done          = (state == FIN);
    done_internal = !((state == PRIME) || ((state == SWEEP) && !last_addr));
  end

  // Address counter, modulus index, latched q and the drain down-counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count     <= '0;
      mod_idx   <= '0;
      q         <= '0;
      read_addr <= '0;
      drain_cnt <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        count   <= num_c;
        mod_idx <= '0;
      end
      if (enter_prime) begin
        mod_idx   <= mod_idx_nxt;
        q         <= tbl_rd;
        read_addr <= '0;
      end else if ((state == SWEEP) && !last_addr) begin
        read_addr <= read_addr + LOGN'(1);
      end else if (state == FIN) begin
        read_addr <= '0;
      end
      if (state == SWEEP) begin
        drain_cnt <= DRAIN_W'(DRAIN_CYCLES - 1);
      end else if ((state == DRAIN) && (drain_cnt != '0)) begin
        drain_cnt <= drain_cnt - DRAIN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rns_error_sequencer.sv
// Directed bench for rns_error_sequencer with N=16 and a converter write-window model.
module tb_rns_error_sequencer;

  localparam int N    = 16;
  localparam int LOGN = 4;
  localparam int LOGQ = 54;
  localparam int MAXL = 8;
  localparam int LOGL = 3;
  localparam int MODC = N + 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cfg_we = 1'b0;
  logic [LOGL-1:0] cfg_idx = '0;
  logic [LOGQ-1:0] cfg_q = '0;
  logic            start = 1'b0;
  logic [LOGL:0]   num_moduli = '0;
  logic            busy;
  logic            done;
  logic [LOGN-1:0] read_addr;
  logic            done_internal;
  logic [LOGQ-1:0] q;
  logic [LOGL-1:0] mod_idx;

  int checks = 0;
  int errors = 0;
  int cycle = 0;

  logic [LOGQ-1:0] tb_tbl [MAXL];

  // converter model state
  logic [2:0]      di_d = 3'b111;
  logic [LOGN-1:0] addr_d0 = '0;
  logic [LOGN-1:0] addr_d1 = '0;
  int              bank_cnt [MAXL];
  int              wr_total = 0;
  int              wr_bad = 0;

  rns_error_sequencer #(
    .N(N), .LOGN(LOGN), .LOGQ(LOGQ), .MAXL(MAXL), .LOGL(LOGL)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_we        (cfg_we),
    .cfg_idx       (cfg_idx),
    .cfg_q         (cfg_q),
    .start         (start),
    .num_moduli    (num_moduli),
    .busy          (busy),
    .done          (done),
    .read_addr     (read_addr),
    .done_internal (done_internal),
    .q             (q),
    .mod_idx       (mod_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Converter: write-enable is done_internal delayed 3 cycles, address is read_addr delayed 2.
  always @(negedge clk) begin
    if (!rst_n) begin
      di_d     <= 3'b111;
      wr_total <= 0;
      wr_bad   <= 0;
      for (int i = 0; i < MAXL; i++) bank_cnt[i] <= 0;
    end else begin
      if (!di_d[2]) begin
        wr_total <= wr_total + 1;
        if (addr_d1 !== LOGN'(bank_cnt[mod_idx]) || q !== tb_tbl[mod_idx]) wr_bad <= wr_bad + 1;
        bank_cnt[mod_idx] <= bank_cnt[mod_idx] + 1;
      end
      di_d    <= {di_d[1:0], done_internal};
      addr_d1 <= addr_d0;
      addr_d0 <= read_addr;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; cfg_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < MAXL; i++) tb_tbl[i] = '0;
  endtask

  task automatic cfg_write(input int idx, input logic [LOGQ-1:0] val);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = LOGL'(idx); cfg_q = val;
    tb_tbl[idx] = val;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Starts a run and checks every cycle against the expected sweep timeline.
  task automatic run_seq(input int num, input int exp_l, input int inj_k, input string tag);
    int last, r, m, p, e_addr, e_mi;
    logic e_busy, e_done, e_di, chk_dp;
    logic [LOGQ-1:0] e_q;
    @(negedge clk);
    start = 1'b1; num_moduli = (LOGL+1)'(num);
    last = 1 + exp_l * MODC;
    for (int k = 1; k <= last + 1; k++) begin
      @(negedge clk);
      start = 1'b0; cfg_we = 1'b0;
      if (k == inj_k) begin
        start = 1'b1; num_moduli = (LOGL+1)'(1);
        cfg_we = 1'b1; cfg_idx = '0; cfg_q = 54'h7F;
      end
      e_addr = 0; e_mi = 0; e_q = '0; chk_dp = 1'b0;
      if (k == last) begin
        e_busy = 1'b0; e_done = 1'b1; e_di = 1'b1;
      end else if (k > last) begin
        e_busy = 1'b0; e_done = 1'b0; e_di = 1'b1;
      end else begin
        r = k - 1; m = r / MODC; p = r % MODC;
        e_busy = 1'b1; e_done = 1'b0; chk_dp = 1'b1;
        e_mi = m; e_q = tb_tbl[LOGL'(m)];
        if (p == 0) begin
          e_addr = 0; e_di = 1'b0;
        end else if (p <= N) begin
          e_addr = p - 1; e_di = (p == N);
        end else begin
          e_addr = N - 1; e_di = 1'b1;
        end
      end
      checks++;
      if (busy !== e_busy) begin
        errors++; $display("FAIL %s busy k=%0d got %b exp %b", tag, k, busy, e_busy);
      end
      checks++;
      if (done !== e_done) begin
        errors++; $display("FAIL %s done k=%0d got %b exp %b", tag, k, done, e_done);
      end
      checks++;
      if (done_internal !== e_di) begin
        errors++; $display("FAIL %s done_internal k=%0d got %b exp %b", tag, k, done_internal, e_di);
      end
      if (chk_dp) begin
        checks++;
        if (read_addr !== LOGN'(e_addr)) begin
          errors++; $display("FAIL %s read_addr k=%0d got %0d exp %0d", tag, k, read_addr, e_addr);
        end
        checks++;
        if (q !== e_q) begin
          errors++; $display("FAIL %s q k=%0d got %h exp %h", tag, k, q, e_q);
        end
        checks++;
        if (mod_idx !== LOGL'(e_mi)) begin
          errors++; $display("FAIL %s mod_idx k=%0d got %0d exp %0d", tag, k, mod_idx, e_mi);
        end
      end
    end
  endtask

  task automatic check_writes(input string tag, input int exp_total);
    checks++;
    if (wr_total !== exp_total) begin
      errors++; $display("FAIL %s write_count got %0d exp %0d", tag, wr_total, exp_total);
    end
    checks++;
    if (wr_bad !== 0) begin
      errors++; $display("FAIL %s bad_writes got %0d exp 0", tag, wr_bad);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done got %b exp 0", done); end
    checks++; if (read_addr !== '0) begin errors++; $display("FAIL reset read_addr got %0d exp 0", read_addr); end
    checks++; if (done_internal !== 1'b1) begin errors++; $display("FAIL reset done_internal got %b exp 1", done_internal); end
    checks++; if (q !== '0) begin errors++; $display("FAIL reset q got %h exp 0", q); end
    checks++; if (mod_idx !== '0) begin errors++; $display("FAIL reset mod_idx got %0d exp 0", mod_idx); end
  endtask

  task automatic test_sweep();
    do_reset();
    cfg_write(0, 54'h3F);
    cfg_write(1, 54'h61);
    run_seq(2, 2, 0, "sweep");
    check_writes("sweep", 2 * N);
    checks++;
    if (bank_cnt[0] !== N || bank_cnt[1] !== N) begin
      errors++; $display("FAIL sweep bank_counts got %0d/%0d exp %0d/%0d", bank_cnt[0], bank_cnt[1], N, N);
    end
  endtask

  task automatic test_zero_moduli();
    do_reset();
    run_seq(0, 0, 0, "zero");
    check_writes("zero", 0);
  endtask

  task automatic test_busy_ignore();
    do_reset();
    cfg_write(0, 54'h3F);
    cfg_write(1, 54'h61);
    run_seq(2, 2, 5, "busy_ignore");
    run_seq(1, 1, 0, "busy_followup");
    check_writes("busy_ignore", 3 * N);
  endtask

  task automatic test_cfg_idle();
    cfg_write(0, 54'h55);
    run_seq(1, 1, 0, "cfg_idle");
    check_writes("cfg_idle", 4 * N);
  endtask

  task automatic test_mid_reset();
    do_reset();
    cfg_write(0, 54'h3F);
    cfg_write(1, 54'h61);
    @(negedge clk);
    start = 1'b1; num_moduli = (LOGL+1)'(2);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (read_addr !== LOGN'(7)) begin
      errors++; $display("FAIL mid_reset pre_addr got %0d exp 7", read_addr);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_reset done got %b exp 0", done); end
    checks++; if (done_internal !== 1'b1) begin errors++; $display("FAIL mid_reset done_internal got %b exp 1", done_internal); end
    checks++; if (read_addr !== '0) begin errors++; $display("FAIL mid_reset read_addr got %0d exp 0", read_addr); end
    checks++; if (q !== '0) begin errors++; $display("FAIL mid_reset q got %h exp 0", q); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < MAXL; i++) tb_tbl[i] = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL mid_reset spurious_done got %b exp 0", done); end
    end
    run_seq(1, 1, 0, "after_reset");
    check_writes("after_reset", N);
  endtask

  task automatic test_clamp();
    do_reset();
    for (int i = 0; i < MAXL; i++) cfg_write(i, LOGQ'(32'h101 + 2 * i));
    run_seq(9, 8, 0, "clamp");
    check_writes("clamp", 8 * N);
  endtask

  initial begin
    for (int i = 0; i < MAXL; i++) tb_tbl[i] = '0;
    test_reset();
    test_sweep();
    test_zero_moduli();
    test_busy_ignore();
    test_cfg_idle();
    test_mid_reset();
    test_clamp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
